// File: rtl/exc_seq.sv
// Exception sequencer between the MIPS decoder and CP0: trap/ERET detection, cause/EPC, strobes, PC redirect.
// Optional build macro STATUS_MASK_EN gates traps with STATUS[0] and per-class mask bits STATUS[3:1].
module exc_seq #(
  parameter logic [31:0] HANDLER_VEC = 32'h00400004
) (
  input  logic        cp0_clk,
  input  logic        cp0_rst,
  input  logic        ena,
  input  logic        inst_valid,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        is_eret,
  input  logic        is_mtc0,
  input  logic        is_mfc0,
  input  logic        rs_eq_rt,
  input  logic [31:0] pc_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] status_in,
  output logic [4:0]  cause_out,
  output logic [31:0] exc_pc,
  output logic        mtc0_out,
  output logic        mfc0_out,
  output logic        eret_out,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic [15:0] exc_count
);

  localparam int unsigned CW = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned NW = 16;

  localparam logic [CW-1:0] CAUSE_SYS = 5'b01000;
  localparam logic [CW-1:0] CAUSE_BRK = 5'b01001;
  localparam logic [CW-1:0] CAUSE_TEQ = 5'b01101;

  typedef enum logic [1:0] {IDLE, SAVE, JUMP, RET} state_t;

  state_t          state_q;
  logic [CW-1:0]   cause_q;
  logic [AW-1:0]   epc_q;
  logic            eret_q;
  logic            redirect_q;
  logic [AW-1:0]   target_q;
  logic            stall_q;
  logic [NW-1:0]   exc_count_q;

  logic            ok_sys_c, ok_brk_c, ok_teq_c;
  logic            take_sys_c, take_brk_c, take_teq_c;
  logic            trap_c, eret_go_c, idle_c;
  logic [CW-1:0]   cause_d;
  logic [AW-1:0]   epc_d;
  logic [NW-1:0]   count_inc_c;

`ifdef STATUS_MASK_EN
  logic            unused_status;
  assign unused_status = ^status_in[31:4];
`else
  logic            unused_status;
  assign unused_status = ^status_in;
`endif

  // Trap qualification, priority encoding and next latched values.
  always_comb begin
`ifdef STATUS_MASK_EN
    ok_sys_c = status_in[0] & status_in[1];
    ok_brk_c = status_in[0] & status_in[2];
    ok_teq_c = status_in[0] & status_in[3];
`else
    ok_sys_c = 1'b1;
    ok_brk_c = 1'b1;
    ok_teq_c = 1'b1;
`endif
    take_sys_c = is_syscall & ok_sys_c;
    take_brk_c = is_break & ok_brk_c;
    take_teq_c = is_teq & rs_eq_rt & ok_teq_c;
    trap_c     = inst_valid & ena & (take_sys_c | take_brk_c | take_teq_c);
    eret_go_c  = inst_valid & ena & is_eret & ~trap_c;
    idle_c     = (state_q == IDLE);
    cause_d    = '0;
    if (take_sys_c)      cause_d = CAUSE_SYS;
    else if (take_brk_c) cause_d = CAUSE_BRK;
    else if (take_teq_c) cause_d = CAUSE_TEQ;
    epc_d       = pc_in + AW'(4);
    count_inc_c = (exc_count_q == '1) ? exc_count_q : exc_count_q + NW'(1);
  end

  // Sequencer: outputs are registered alongside the state they belong to.
  always_ff @(posedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      state_q     <= IDLE;
      cause_q     <= '0;
      epc_q       <= '0;
      eret_q      <= 1'b0;
      redirect_q  <= 1'b0;
      target_q    <= '0;
      stall_q     <= 1'b0;
      exc_count_q <= '0;
    end else if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (trap_c) begin
            state_q <= SAVE;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            stall_q <= 1'b1;
          end else if (eret_go_c) begin
            state_q    <= RET;
            eret_q     <= 1'b1;
            redirect_q <= 1'b1;
            target_q   <= epc_in;
            stall_q    <= 1'b1;
          end
        end
        SAVE: begin
          state_q     <= JUMP;
          cause_q     <= '0;
          epc_q       <= '0;
          redirect_q  <= 1'b1;
          target_q    <= HANDLER_VEC;
          exc_count_q <= count_inc_c;
        end
        JUMP: begin
          state_q    <= IDLE;
          redirect_q <= 1'b0;
          target_q   <= '0;
          stall_q    <= 1'b0;
        end
        RET: begin
          state_q    <= IDLE;
          eret_q     <= 1'b0;
          redirect_q <= 1'b0;
          target_q   <= '0;
          stall_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes drop immediately while ena is low; stall and payloads hold.
  assign mtc0_out        = is_mtc0 & inst_valid & ena & idle_c & ~trap_c;
  assign mfc0_out        = is_mfc0 & inst_valid & ena & idle_c & ~trap_c;
  assign eret_out        = eret_q & ena;
  assign pc_redirect     = redirect_q & ena;
  assign cause_out       = cause_q;
  assign exc_pc          = epc_q;
  assign redirect_target = target_q;
  assign stall           = stall_q;
  assign exc_count       = exc_count_q;

endmodule

// File: tb/tb_exc_seq.sv
// Self-checking bench for exc_seq: directed scenarios plus randomized traffic against a phase-queue model.
module tb_exc_seq;

  localparam logic [31:0] HVEC = 32'h00400004;

  logic        cp0_clk = 1'b0;
  logic        cp0_rst;
  logic        ena, inst_valid;
  logic        is_syscall, is_break, is_teq, is_eret, is_mtc0, is_mfc0, rs_eq_rt;
  logic [31:0] pc_in, epc_in, status_in;
  logic [4:0]  cause_out;
  logic [31:0] exc_pc, redirect_target;
  logic        mtc0_out, mfc0_out, eret_out, stall, pc_redirect;
  logic [15:0] exc_count;

  int tests_run    = 0;
  int tests_failed = 0;

  exc_seq #(.HANDLER_VEC(HVEC)) dut (
    .cp0_clk(cp0_clk), .cp0_rst(cp0_rst), .ena(ena), .inst_valid(inst_valid),
    .is_syscall(is_syscall), .is_break(is_break), .is_teq(is_teq), .is_eret(is_eret),
    .is_mtc0(is_mtc0), .is_mfc0(is_mfc0), .rs_eq_rt(rs_eq_rt),
    .pc_in(pc_in), .epc_in(epc_in), .status_in(status_in),
    .cause_out(cause_out), .exc_pc(exc_pc), .mtc0_out(mtc0_out), .mfc0_out(mfc0_out),
    .eret_out(eret_out), .stall(stall), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .exc_count(exc_count)
  );

  always #5 cp0_clk = ~cp0_clk;

  logic [87:0] obs;
  assign obs = {cause_out, exc_pc, eret_out, pc_redirect, redirect_target, stall, exc_count};

  function automatic logic [87:0] pack(input logic [4:0] c, input logic [31:0] e, input logic er,
                                       input logic rd, input logic [31:0] t, input logic s,
                                       input logic [15:0] n);
    return {c, e, er, rd, t, s, n};
  endfunction

  // Cause code the architecture would take for the current inputs, 0 when none.
  function automatic logic [4:0] model_code();
    logic s, b, t;
    if (!(inst_valid && ena)) return 5'd0;
`ifdef STATUS_MASK_EN
    s = status_in[0] & status_in[1];
    b = status_in[0] & status_in[2];
    t = status_in[0] & status_in[3];
`else
    s = 1'b1; b = 1'b1; t = 1'b1;
`endif
    if (is_syscall && s) return 5'b01000;
    if (is_break && b) return 5'b01001;
    if (is_teq && rs_eq_rt && t) return 5'b01101;
    return 5'd0;
  endfunction

  task automatic idle_inputs();
    ena = 1'b1; inst_valid = 1'b0; rs_eq_rt = 1'b0;
    is_syscall = 1'b0; is_break = 1'b0; is_teq = 1'b0;
    is_eret = 1'b0; is_mtc0 = 1'b0; is_mfc0 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    pc_in = '0; epc_in = '0; status_in = 32'h0000000F;
    cp0_rst = 1'b1;
    @(negedge cp0_clk);
    @(negedge cp0_clk);
    cp0_rst = 1'b0;
  endtask

  task automatic next();
    @(posedge cp0_clk);
    @(negedge cp0_clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    status_in = 32'h0000000F; pc_in = 32'h12345678; epc_in = 32'h9abcdef0;
    cp0_rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== 88'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected %h", obs, 88'd0);
    end
    tests_run++;
    if ({mtc0_out, mfc0_out} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_strobes: got %b expected 00", {mtc0_out, mfc0_out});
    end
    @(negedge cp0_clk);
    cp0_rst = 1'b0;
  endtask

  task automatic test_syscall();
    int stall_cycles = 0;
    logic [87:0] exp;
    do_reset();
    inst_valid = 1'b1; is_syscall = 1'b1; pc_in = 32'h00400100;
    next();
    idle_inputs();
    stall_cycles += int'(stall);
    exp = pack(5'b01000, 32'h00400104, 1'b0, 1'b0, 32'd0, 1'b1, 16'd0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL syscall_save: got %h expected %h", obs, exp);
    end
    next();
    stall_cycles += int'(stall);
    exp = pack(5'd0, 32'd0, 1'b0, 1'b1, HVEC, 1'b1, 16'd1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL syscall_jump: got %h expected %h", obs, exp);
    end
    next();
    stall_cycles += int'(stall);
    exp = pack(5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL syscall_done: got %h expected %h", obs, exp);
    end
    tests_run++;
    if (stall_cycles != 2) begin
      tests_failed++; $display("FAIL syscall_stall_len: got %0d expected 2", stall_cycles);
    end
    // EPC wraps past the top of the address space.
    inst_valid = 1'b1; is_break = 1'b1; pc_in = 32'hFFFFFFFC;
    next();
    idle_inputs();
    exp = pack(5'b01001, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 16'd1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL break_wrap: got %h expected %h", obs, exp);
    end
    next();
    next();
    tests_run++;
    if (exc_count !== 16'd2) begin
      tests_failed++; $display("FAIL count_two: got %0d expected 2", exc_count);
    end
  endtask

  task automatic test_priority();
    logic [87:0] exp;
    do_reset();
    inst_valid = 1'b1; is_syscall = 1'b1; is_break = 1'b1; is_eret = 1'b1;
    pc_in = 32'h00001000; epc_in = 32'h00005000;
    next();
    idle_inputs();
    exp = pack(5'b01000, 32'h00001004, 1'b0, 1'b0, 32'd0, 1'b1, 16'd0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL prio_save: got %h expected %h", obs, exp);
    end
    next();
    exp = pack(5'd0, 32'd0, 1'b0, 1'b1, HVEC, 1'b1, 16'd1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL prio_jump: got %h expected %h", obs, exp);
    end
    next();
  endtask

  task automatic test_teq();
    logic [87:0] exp;
    do_reset();
    inst_valid = 1'b1; is_teq = 1'b1; rs_eq_rt = 1'b0; pc_in = 32'h00002000;
    next();
    tests_run++;
    if (obs !== 88'd0) begin
      tests_failed++; $display("FAIL teq_noop: got %h expected %h", obs, 88'd0);
    end
    rs_eq_rt = 1'b1;
    next();
    idle_inputs();
    exp = pack(5'b01101, 32'h00002004, 1'b0, 1'b0, 32'd0, 1'b1, 16'd0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL teq_taken: got %h expected %h", obs, exp);
    end
    next();
    next();
  endtask

  task automatic test_eret();
    logic [87:0] exp;
    do_reset();
    inst_valid = 1'b1; is_eret = 1'b1; epc_in = 32'h00400104;
    next();
    idle_inputs();
    exp = pack(5'd0, 32'd0, 1'b1, 1'b1, 32'h00400104, 1'b1, 16'd0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL eret_ret: got %h expected %h", obs, exp);
    end
    next();
    tests_run++;
    if (obs !== 88'd0) begin
      tests_failed++; $display("FAIL eret_done: got %h expected %h", obs, 88'd0);
    end
  endtask

  task automatic test_cop0();
    do_reset();
    inst_valid = 1'b1; is_mtc0 = 1'b1;
    #1;
    tests_run++;
    if ({mtc0_out, mfc0_out} !== 2'b10) begin
      tests_failed++; $display("FAIL mtc0_idle: got %b expected 10", {mtc0_out, mfc0_out});
    end
    is_mtc0 = 1'b0; is_mfc0 = 1'b1;
    #1;
    tests_run++;
    if ({mtc0_out, mfc0_out} !== 2'b01) begin
      tests_failed++; $display("FAIL mfc0_idle: got %b expected 01", {mtc0_out, mfc0_out});
    end
    ena = 1'b0;
    #1;
    tests_run++;
    if (mfc0_out !== 1'b0) begin
      tests_failed++; $display("FAIL mfc0_disabled: got %b expected 0", mfc0_out);
    end
    ena = 1'b1; is_syscall = 1'b1; pc_in = 32'h00000040;
    #1;
    tests_run++;
    if (mfc0_out !== 1'b0) begin
      tests_failed++; $display("FAIL mfc0_vs_trap: got %b expected 0", mfc0_out);
    end
    next();
    is_syscall = 1'b0;
    #1;
    tests_run++;
    if (mfc0_out !== 1'b0) begin
      tests_failed++; $display("FAIL mfc0_busy: got %b expected 0", mfc0_out);
    end
    idle_inputs();
    next();
    next();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    inst_valid = 1'b1; is_syscall = 1'b1; pc_in = 32'h00003000;
    next();
    idle_inputs();
    cp0_rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== 88'd0) begin
      tests_failed++; $display("FAIL rst_in_save: got %h expected %h", obs, 88'd0);
    end
    @(negedge cp0_clk);
    cp0_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next();
      seen += int'(pc_redirect) + int'(stall);
    end
    tests_run++;
    if (seen != 0 || exc_count !== 16'd0) begin
      tests_failed++; $display("FAIL rst_no_redirect: got activity %0d count %0d expected 0 0", seen, exc_count);
    end
  endtask

`ifdef STATUS_MASK_EN
  task automatic test_mask();
    logic [87:0] exp;
    do_reset();
    status_in = 32'h1;
    inst_valid = 1'b1; is_break = 1'b1; pc_in = 32'h00004000;
    next();
    tests_run++;
    if (obs !== 88'd0) begin
      tests_failed++; $display("FAIL mask_break_off: got %h expected %h", obs, 88'd0);
    end
    status_in = 32'h5;
    next();
    idle_inputs();
    exp = pack(5'b01001, 32'h00004004, 1'b0, 1'b0, 32'd0, 1'b1, 16'd0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL mask_break_on: got %h expected %h", obs, exp);
    end
    next();
    next();
  endtask
`endif

  typedef struct {
    int          kind;   // 1 save, 2 jump, 3 ret
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [31:0] tgt;
  } phase_t;

  task automatic test_random();
    phase_t      q[$];
    phase_t      ph;
    logic [15:0] cnt = 16'd0;
    logic [4:0]  code;
    logic [87:0] exp;
    logic [1:0]  exp_cop;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ena        = ($urandom_range(0, 9) != 0);
      inst_valid = ($urandom_range(0, 3) != 0);
      is_syscall = ($urandom_range(0, 9) == 0);
      is_break   = ($urandom_range(0, 9) == 0);
      is_teq     = ($urandom_range(0, 5) == 0);
      is_eret    = ($urandom_range(0, 7) == 0);
      is_mtc0    = ($urandom_range(0, 3) == 0);
      is_mfc0    = ($urandom_range(0, 3) == 0);
      rs_eq_rt   = 1'($urandom_range(0, 1));
      pc_in      = $urandom() & 32'hFFFFFFFC;
      status_in  = $urandom();
      if (q.size() == 0 && $urandom_range(0, 3) == 0) epc_in = $urandom();
      #1;
      code = model_code();
      exp_cop = (q.size() == 0 && inst_valid && ena && code == 5'd0) ? {is_mtc0, is_mfc0} : 2'b00;
      tests_run++;
      if ({mtc0_out, mfc0_out} !== exp_cop) begin
        tests_failed++; $display("FAIL rand_cop0 @%0d: got %b expected %b", i, {mtc0_out, mfc0_out}, exp_cop);
      end
      if (q.size() == 0) begin
        if (code != 5'd0) begin
          q.push_back('{kind: 1, cause: code, epc: pc_in + 32'd4, tgt: 32'd0});
          q.push_back('{kind: 2, cause: 5'd0, epc: 32'd0, tgt: HVEC});
        end else if (inst_valid && ena && is_eret) begin
          q.push_back('{kind: 3, cause: 5'd0, epc: 32'd0, tgt: epc_in});
        end
      end else if (ena) begin
        if (q[0].kind == 1 && cnt != 16'hFFFF) cnt = cnt + 16'd1;
        void'(q.pop_front());
      end
      next();
      if (q.size() == 0) exp = pack(5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, cnt);
      else begin
        ph = q[0];
        case (ph.kind)
          1:       exp = pack(ph.cause, ph.epc, 1'b0, 1'b0, 32'd0, 1'b1, cnt);
          2:       exp = pack(5'd0, 32'd0, 1'b0, ena, ph.tgt, 1'b1, cnt);
          default: exp = pack(5'd0, 32'd0, ena, ena, ph.tgt, 1'b1, cnt);
        endcase
      end
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL rand_outputs @%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    cp0_rst = 1'b1;
    idle_inputs();
    pc_in = '0; epc_in = '0; status_in = 32'h0000000F;
    @(negedge cp0_clk);
    test_reset();
    test_syscall();
    test_priority();
    test_teq();
    test_eret();
    test_cop0();
    test_reset_mid();
`ifdef STATUS_MASK_EN
    test_mask();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
